// File: rtl/key_move_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_move_queue                                                |
// | Purpose  : Turns the keypad scanner's held-key level into discrete maze   |
// |            move commands (one per press, auto-repeat for held direction  |
// |            keys) and buffers them in a first-word-fall-through FIFO.     |
// | Ports    : clk        - system clock, rising edge                         |
// |            reset      - asynchronous active-high reset                   |
// |            key_valid  - scanner key-present level (asynchronous)         |
// |            key_value  - scanner key code 0..15                           |
// |            cmd_pop    - consumer takes the head entry this cycle         |
// |            cmd_valid  - FIFO non-empty                                   |
// |            cmd        - head command, 0 when empty                       |
// |            overflow   - sticky, a command was dropped on a full FIFO     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_move_queue #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int DEPTH_LOG2    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       cmd_pop,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0]    HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  // Two-flop synchronizers for the scanner signals.
  logic       v_s1, v_s2;
  logic [3:0] k_s1, k_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_s1 <= 1'b0;
      v_s2 <= 1'b0;
      k_s1 <= 4'd0;
      k_s2 <= 4'd0;
    end else begin
      v_s1 <= key_valid;
      v_s2 <= v_s1;
      k_s1 <= key_value;
      k_s2 <= k_s1;
    end
  end

  // Key code to move command.
  logic [2:0] mapped_cmd;
  logic       mapped_dir;

  always_comb begin
    mapped_cmd = 3'd0;
    case (k_s2)
      4'd1:    mapped_cmd = 3'd1;
      4'd4:    mapped_cmd = 3'd2;
      4'd6:    mapped_cmd = 3'd3;
      4'd9:    mapped_cmd = 3'd4;
      4'd0:    mapped_cmd = 3'd5;
      4'd15:   mapped_cmd = 3'd6;
      default: mapped_cmd = 3'd0;
    endcase
  end

  assign mapped_dir = (mapped_cmd >= 3'd1) && (mapped_cmd <= 3'd4);

  // Press / auto-repeat FSM.
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       latched, latched_nxt;
  logic             push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      latched <= 3'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      latched <= latched_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    latched_nxt = latched;
    push        = 1'b0;
    case (state)
      S_IDLE: begin
        if (v_s2) begin
          latched_nxt = mapped_cmd;
          cnt_nxt     = '0;
          if (mapped_dir) begin
            push      = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            // Restart/pause push once; unmapped codes push nothing.
            push      = (mapped_cmd != 3'd0);
            state_nxt = S_WAIT;
          end
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          push      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_REPEAT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (cnt == REPEAT_LAST) begin
          push    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT:  state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
    // A release overrides everything, including a same-cycle expiry.
    if (!v_s2) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      push      = 1'b0;
    end
  end

  // First-word-fall-through FIFO.
  logic [2:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, do_pop, do_push;

  assign full    = (count == FULL_COUNT);
  assign do_pop  = cmd_pop && cmd_valid;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= latched_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign cmd_valid = (count != '0);
  assign cmd       = cmd_valid ? mem[rd_ptr] : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_key_move_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_key_move_queue                                             |
// | Purpose  : Self-checking bench for key_move_queue with a timeline-based   |
// |            reference model and directed hand-computed expectations.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_key_move_queue;

  localparam int HOLD   = 8;
  localparam int REPEAT = 4;
  localparam int DLOG2  = 2;
  localparam int DEPTH  = 1 << DLOG2;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_value;
  logic       cmd_pop;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  key_move_queue #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REPEAT),
    .DEPTH_LOG2   (DLOG2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .key_value(key_value),
    .cmd_pop  (cmd_pop),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] key_to_cmd(input logic [3:0] k);
    case (k)
      4'd1:    return 3'd1;
      4'd4:    return 3'd2;
      4'd6:    return 3'd3;
      4'd9:    return 3'd4;
      4'd0:    return 3'd5;
      4'd15:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Reference model: tracks elapsed held time since the first command and
  // derives pushes from it; the FIFO is a plain queue.
  logic       m_v1, m_v2;
  logic [3:0] m_k1, m_k2;
  logic       m_active;
  int         m_t;
  logic [2:0] m_cmd;
  logic       m_push;
  logic       m_ovf;
  logic [2:0] mq[$];

  always @(posedge clk) begin
    if (reset) begin
      m_v1 = 0; m_v2 = 0; m_k1 = 0; m_k2 = 0;
      m_active = 0; m_t = 0; m_cmd = 0; m_ovf = 0;
      mq.delete();
    end else begin
      m_push = 0;
      if (!m_v2) begin
        m_active = 0;
        m_t      = 0;
      end else if (!m_active) begin
        m_active = 1;
        m_cmd    = key_to_cmd(m_k2);
        m_t      = 0;
        m_push   = (m_cmd != 0);
      end else begin
        m_t++;
        if (m_cmd >= 1 && m_cmd <= 4 &&
            (m_t == HOLD || (m_t > HOLD && (m_t - HOLD) % REPEAT == 0)))
          m_push = 1;
      end
      if (cmd_pop && mq.size() != 0) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_cmd);
        else m_ovf = 1;
      end
      m_v2 = m_v1; m_v1 = key_valid;
      m_k2 = m_k1; m_k1 = key_value;
    end
    #1;
    check("model cmd_valid", int'(cmd_valid), (mq.size() != 0) ? 1 : 0);
    check("model cmd", int'(cmd), (mq.size() != 0) ? int'(mq[0]) : 0);
    check("model overflow", int'(overflow), int'(m_ovf));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    cmd_pop = 1'b1;
    @(negedge clk);
    cmd_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_value = 4'd0; cmd_pop = 1'b0;
    @(negedge clk);
    cycles(2);
    check("reset cmd_valid", int'(cmd_valid), 0);
    check("reset cmd", int'(cmd), 0);
    check("reset overflow", int'(overflow), 0);
    reset = 1'b0;
    cycles(2);

    // Tap key 6 for three edges; latency of two edges to the first entry.
    key_valid = 1'b1; key_value = 4'd6;
    repeat (2) @(posedge clk);
    #1 check("tap latency N+1", int'(cmd_valid), 0);
    @(posedge clk);
    #1 check("tap latency N+2 valid", int'(cmd_valid), 1);
    check("tap cmd", int'(cmd), 3);
    @(negedge clk);
    key_valid = 1'b0;
    cycles(4);
    check("tap single entry cmd", int'(cmd), 3);
    cmd_pop = 1'b1;
    @(posedge clk);
    #1 check("tap pop empties", int'(cmd_valid), 0);
    @(negedge clk);
    cmd_pop = 1'b0;
    cycles(2);

    // Restart key: one entry, no repeats.
    key_valid = 1'b1; key_value = 4'd0;
    cycles(50);
    key_valid = 1'b0;
    cycles(4);
    check("restart cmd", int'(cmd), 5);
    pop_one();
    check("restart no repeat", int'(cmd_valid), 0);
    // Unmapped key 7: nothing.
    key_valid = 1'b1; key_value = 4'd7;
    cycles(20);
    key_valid = 1'b0;
    cycles(4);
    check("unmapped no entry", int'(cmd_valid), 0);

    // Key 9 fills the FIFO; the 5th push coincides with a pop.
    key_valid = 1'b1; key_value = 4'd9;
    cycles(22);
    cmd_pop = 1'b1;
    cycles(1);
    cmd_pop = 1'b0;
    key_valid = 1'b0;
    check("full+pop overflow", int'(overflow), 0);
    check("full+pop cmd", int'(cmd), 4);
    cycles(4);
    for (int i = 0; i < 3; i++) begin
      check("full+pop drain cmd", int'(cmd), 4);
      pop_one();
    end
    check("full+pop count was 4", int'(cmd_valid), 1);
    pop_one();
    check("full+pop drained", int'(cmd_valid), 0);
    cycles(2);

    // Release on the exact edge the hold period would expire.
    key_valid = 1'b1; key_value = 4'd6;
    cycles(8);
    key_valid = 1'b0;
    cycles(10);
    check("release-expiry cmd", int'(cmd), 3);
    pop_one();
    check("release-expiry no repeat", int'(cmd_valid), 0);
    cycles(2);

    // Key 1 held: pushes at E, E+8, E+12, E+16; E+20 is dropped.
    key_valid = 1'b1; key_value = 4'd1;
    cycles(19);
    check("hold 4 pushes no overflow", int'(overflow), 0);
    cycles(4);
    check("hold 5th push overflow", int'(overflow), 1);
    key_valid = 1'b0;
    cycles(4);
    pop_one();
    check("3 queued valid", int'(cmd_valid), 1);
    check("3 queued cmd", int'(cmd), 1);

    // Asynchronous reset with a key held across it.
    reset = 1'b1; key_valid = 1'b1; key_value = 4'd4;
    #1;
    check("async reset cmd_valid", int'(cmd_valid), 0);
    check("async reset cmd", int'(cmd), 0);
    check("async reset overflow", int'(overflow), 0);
    @(negedge clk);
    cycles(2);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("post-reset R+1 empty", int'(cmd_valid), 0);
    @(posedge clk);
    #1 check("post-reset R+2 valid", int'(cmd_valid), 1);
    check("post-reset cmd", int'(cmd), 2);
    @(negedge clk);
    key_valid = 1'b0;
    cycles(5);
    pop_one();
    check("post-reset single entry", int'(cmd_valid), 0);
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_move_queue.md
# key_move_queue

Converts the keypad scanner's held-key output (`key_value` plus a key-present level) into discrete maze-move commands. It synchronizes the scanner signals into the system clock domain and emits one command per press, with auto-repeat for held direction keys. Commands are buffered in a small first-word-fall-through FIFO that the maze engine drains. The block sits between the 4x4 keypad scanner and the maze movement/game-control logic.

## Interface
- `HOLD_CYCLES`, default 25_000_000: `clk` cycles a direction key must stay held after its first command before auto-repeat begins (0.5 s at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: `clk` cycles between auto-repeat commands; must be ≥ 2.
- `DEPTH_LOG2`, default 2: FIFO depth is 2^DEPTH_LOG2 entries.
- `clk` in 1: 50 MHz system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `key_valid` in 1: high while the scanner reports a held key; asynchronous to `clk`.
- `key_value` in 4: scanner key code 0–15; stable while `key_valid` is high.
- `cmd_pop` in 1: consumer acknowledges the head entry this cycle.
- `cmd_valid` out 1: FIFO non-empty.
- `cmd` out 3: head command; 3'd0 when empty.
- `overflow` out 1: sticky; a command was dropped because the FIFO was full.

## Operation
- Synchronizer: `key_valid` and `key_value` each pass through two flops (`v_s2`, `k_s2`). The FSM uses only the `_s2` copies.
- Key map (`k_s2` → cmd): 1→UP 3'd1, 4→LEFT 3'd2, 6→RIGHT 3'd3, 9→DOWN 3'd4, 0→RESTART 3'd5, 15→PAUSE 3'd6. All other codes map to none.
- FSM states: IDLE, HOLD, REPEAT, WAIT. A counter of width clog2(max(HOLD_CYCLES,REPEAT_CYCLES)) supports the timed states.
  - IDLE, `v_s2`=1: latch the mapped cmd.
    - Direction: push, then HOLD with counter 0.
    - RESTART/PAUSE: push, then WAIT.
    - Unmapped: no push, then WAIT.
  - HOLD: counter increments each cycle. At counter == HOLD_CYCLES-1, push the latched cmd, clear the counter, go to REPEAT.
  - REPEAT: at counter == REPEAT_CYCLES-1, push the latched cmd and clear the counter; stay in REPEAT.
  - WAIT: no pushes.
  - Any state, `v_s2`=0: go to IDLE and clear the counter. Release takes priority over an expiry in the same cycle, so no push occurs.
- A code change while `v_s2` stays high is ignored. The latched cmd stays in force until release.
- FIFO behaviour:
  - Circular buffer with read/write pointers and a count of DEPTH_LOG2+1 bits.
  - Push writes at the tail.
  - Pop occurs when `cmd_pop && cmd_valid`. `cmd_pop` while empty is ignored.
  - Push and pop in the same cycle both take effect; the count is unchanged, including when full.
  - Push while full with no pop: the command is dropped and `overflow` is set to 1. Only `reset` clears `overflow`.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- `cmd` and `cmd_valid` are driven from registers (head entry / count≠0), with no combinational path from inputs.

## Timing
- Reset values: `cmd_valid`=0, `cmd`=0, `overflow`=0. FSM is IDLE, counter 0, FIFO empty, synchronizer flops 0.
- Asserting `reset` mid-operation discards queued commands and any in-progress hold. After release, a still-held key produces a fresh first command, since `v_s2` rises again.
- Press latency: `key_valid` high at edge N gives `cmd_valid` high after edge N+2, assuming the FIFO was empty.
- Release latency: `key_valid` low at edge N gives FSM IDLE after edge N+2.
- Repeat timing: first push at edge E. With the key held, repeats occur at E+HOLD_CYCLES, then every REPEAT_CYCLES.
- Pop: entry removed on the edge where `cmd_pop`=1. The next entry, or `cmd_valid`=0, appears right after that edge.

## Test plan
Benches use HOLD_CYCLES=8, REPEAT_CYCLES=4, DEPTH_LOG2=2.
- Tap key 6 for 3 cycles -> exactly one entry `cmd`=3. Hold `cmd_pop`=1 -> `cmd_valid` drops after one edge.
- Hold key 1 for 20 cycles after first push, no pops -> pushes at E, E+8, E+12, E+16, E+20. FIFO full after 4 pushes; 5th is dropped and `overflow`=1.
- Hold key 0 for 50 cycles -> single entry 5, no repeats. Key 7 held -> no entries.
- FIFO full with `cmd_pop`=1 on the same cycle as a repeat push -> count stays 4, `overflow` stays 0, order preserved.
- Release key on the exact cycle the HOLD counter expires -> no repeat push, FSM IDLE.
- Assert `reset` with 3 entries queued and `overflow`=1 -> all outputs 0 immediately (asynchronous). A key held across reset yields one new entry 2 edges after reset deasserts.
